// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding-mux selects
// and wait-state FSM codes, kept as plain constants for legacy decoders.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  localparam logic [1:0] WS_RUN   = 2'd0;
  localparam logic [1:0] WS_DWAIT = 2'd1;
  localparam logic [1:0] WS_IWAIT = 2'd2;

  localparam int unsigned WAIT_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage in-order pipeline,
// with a memory wait-state FSM, sticky timeout watchdog and perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regw,
  input  logic             ex_memr,
  input  logic             ex_redirect,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_regw,
  input  logic             mem_memr,
  input  logic             wb_regw,
  input  logic             imem_ready,
  input  logic             dmem_access,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_stall,
  output logic             mem_stall,
  output logic             wb_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       wait_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(WAIT_LIMIT);

  logic                  cond_d, cond_l, cond_r, cond_i;
  logic [1:0]            state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  // A loaded value in MEM is not yet available, so only ALU results forward from MEM.
  function automatic logic [1:0] fwd_for(
    input logic [REG_W-1:0] r,
    input logic [REG_W-1:0] m_rd,
    input logic             m_regw,
    input logic             m_memr,
    input logic [REG_W-1:0] w_rd,
    input logic             w_regw
  );
    if (r == '0)                              return FWD_RF;
    else if (m_regw && !m_memr && m_rd == r)  return FWD_MEM;
    else if (w_regw && w_rd == r)             return FWD_WB;
    else                                      return FWD_RF;
  endfunction

  assign fwd_sel_a = fwd_for(ex_rs, mem_rd, mem_regw, mem_memr, wb_rd, wb_regw);
  assign fwd_sel_b = fwd_for(ex_rt, mem_rd, mem_regw, mem_memr, wb_rd, wb_regw);

  assign cond_d = dmem_access && !dmem_ready;
  assign cond_l = ex_memr && ex_regw && (ex_rd != '0) &&
                  ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
  assign cond_r = ex_redirect;
  assign cond_i = !imem_ready;

  always_comb begin
    if_stall     = 1'b0;
    id_stall     = 1'b0;
    ex_stall     = 1'b0;
    mem_stall    = 1'b0;
    wb_stall     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (cond_d) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
      wb_stall  = 1'b1;
    end else if (cond_r) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (cond_l) begin
      if_stall    = 1'b1;
      id_stall    = 1'b1;
      id_ex_flush = 1'b1;
    end else if (cond_i) begin
      if_stall    = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = wait_state;
    case (wait_state)
      WS_RUN:   if (cond_d) state_nxt = WS_DWAIT;
                else if (cond_i && !cond_r) state_nxt = WS_IWAIT;
      WS_DWAIT: if (!cond_d) state_nxt = WS_RUN;
      WS_IWAIT: if (cond_d) state_nxt = WS_DWAIT;
                else if (imem_ready) state_nxt = WS_RUN;
      default:  state_nxt = WS_RUN;
    endcase
  end

  // wait_cnt stops at LIMIT so a very long wait cannot wrap the watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_state  <= WS_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_state <= state_nxt;
      if (state_nxt == WS_RUN)
        wait_cnt <= '0;
      else if (wait_state != WS_RUN && (cond_d || cond_i) && wait_cnt != LIMIT) begin
        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        if (wait_cnt + WAIT_CNT_W'(1) == LIMIT)
          mem_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cond_d || (cond_i && !cond_r)),
    .clr   (cnt_clr),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cond_l && !cond_d && !cond_r),
    .clr   (cnt_clr),
    .count (bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cond_r),
    .clr   (cnt_clr),
    .count (flush_cnt)
  );

endmodule
